// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID latch and RUN/HOLD/HALT control.
// Optional HOLD watchdog compiled in with FETCH_HOLD_TIMEOUT_EN.
module fetch_unit (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_instr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr_out,
    output logic [15:0] PC_out,
    output logic        valid_out,
    output logic        PC_hazard_out,
    output logic        halted,
    output logic        hold_timeout
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 4;
    localparam int unsigned CNTW = 3;

    localparam logic [OPW-1:0] OP_CALL = 4'hD;
    localparam logic [OPW-1:0] OP_RET  = 4'hE;
    localparam logic [OPW-1:0] OP_HLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pcout_q, pcout_d;
    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_inc;
    logic [OPW-1:0]    opcode;

`ifdef FETCH_HOLD_TIMEOUT_EN
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(6);
`endif

    assign pc_inc = pc_q + XLEN'(1);
    assign opcode = imem_instr[XLEN-1:XLEN-OPW];

    // Next-state and IF/ID update; redirect wins over stall, stall over state action
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        valid_d = valid_q;
`ifdef FETCH_HOLD_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif
        if (redirect) begin
            pc_d    = redirect_pc;
            instr_d = '0;
            valid_d = 1'b0;
            state_d = ST_RUN;
`ifdef FETCH_HOLD_TIMEOUT_EN
            cnt_d   = '0;
`endif
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    instr_d = imem_instr;
                    pcout_d = pc_inc;
                    valid_d = 1'b1;
                    if (opcode == OP_HLT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_inc;
                        if (opcode == OP_CALL || opcode == OP_RET) begin
                            state_d = ST_HOLD;
`ifdef FETCH_HOLD_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
                ST_HOLD: begin
                    instr_d = '0;
                    valid_d = 1'b0;
`ifdef FETCH_HOLD_TIMEOUT_EN
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d   = ST_RUN;
                        timeout_d = 1'b1;
                    end
`endif
                end
                ST_HALT: begin
                    instr_d = '0;
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            instr_q <= '0;
            pcout_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
            valid_q <= valid_d;
        end
    end

`ifdef FETCH_HOLD_TIMEOUT_EN
    // Watchdog counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign hold_timeout = timeout_q;
`else
    assign hold_timeout = 1'b0;
`endif

    assign imem_addr     = pc_q;
    assign instr_out     = instr_q;
    assign PC_out        = pcout_q;
    assign valid_out     = valid_q;
    assign PC_hazard_out = (state_q == ST_HOLD);
    assign halted        = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random stimulus vs a behavioural model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] instr_out;
    logic [15:0] PC_out;
    logic        valid_out;
    logic        PC_hazard_out;
    logic        halted;
    logic        hold_timeout;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .instr_out     (instr_out),
        .PC_out        (PC_out),
        .valid_out     (valid_out),
        .PC_hazard_out (PC_hazard_out),
        .halted        (halted),
        .hold_timeout  (hold_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    // Behavioural model: fetch mode, pc, IF/ID contents, watchdog count, sticky flag
    localparam int M_RUN = 0, M_HOLD = 1, M_HALT = 2;
    int          m_mode;
    logic [15:0] m_pc, m_instr, m_pcout;
    logic        m_valid, m_to;
    int          m_cnt;

    wire [51:0] dut_v = {instr_out, PC_out, imem_addr, valid_out, PC_hazard_out, halted, hold_timeout};

    function automatic logic [51:0] exp_v();
        return {m_instr, m_pcout, m_pc, m_valid, m_mode == M_HOLD, m_mode == M_HALT, m_to};
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_pc = 0; m_instr = 0; m_pcout = 0; m_valid = 0; m_to = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic st, input logic rd, input logic [15:0] rpc, input logic [15:0] ins);
        if (rd) begin
            m_pc = rpc; m_instr = 0; m_valid = 0; m_mode = M_RUN;
        end else if (!st) begin
            if (m_mode == M_RUN) begin
                m_instr = ins; m_valid = 1; m_pcout = m_pc + 16'd1;
                if (ins[15:12] == 4'hF) m_mode = M_HALT;
                else begin
                    m_pc = m_pc + 16'd1;
                    if (ins[15:12] == 4'hD || ins[15:12] == 4'hE) begin
                        m_mode = M_HOLD; m_cnt = 0;
                    end
                end
            end else begin
                m_instr = 0; m_valid = 0;
`ifdef FETCH_HOLD_TIMEOUT_EN
                if (m_mode == M_HOLD) begin
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 7) begin m_mode = M_RUN; m_to = 1; end
                end
`endif
            end
        end
    endtask

    // Drive one cycle of inputs, clock it, and advance the model
    task automatic step(input logic st, input logic rd, input logic [15:0] rpc, input logic [15:0] ins);
        stall = st; redirect = rd; redirect_pc = rpc; imem_instr = ins;
        @(posedge clk); #1;
        model_edge(st, rd, rpc, ins);
        stall = 1'b0; redirect = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (dut_v !== 52'h0) begin
            bad++; $display("FAIL reset_async: got %h expected %h", dut_v, 52'h0);
        end
        @(posedge clk); #1;
        total++;
        if (dut_v !== 52'h0) begin
            bad++; $display("FAIL reset_held: got %h expected %h", dut_v, 52'h0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'h0, 16'h1123);
            total++;
            if (dut_v !== exp_v()) begin
                bad++; $display("FAIL seq_model[%0d]: got %h expected %h", i, dut_v, exp_v());
            end
            total++;
            if (PC_out !== 16'(i + 1) || instr_out !== 16'h1123 || valid_out !== 1'b1) begin
                bad++; $display("FAIL seq_pcout[%0d]: got %h/%h/%b expected %h/1123/1", i, PC_out, instr_out, valid_out, 16'(i + 1));
            end
        end
    endtask

    task automatic test_call();
        step(1'b0, 1'b0, 16'h0, 16'h1123);
        step(1'b0, 1'b0, 16'h0, 16'hD00A);
        total++;
        if (instr_out !== 16'hD00A || PC_out !== 16'h0006 || PC_hazard_out !== 1'b1) begin
            bad++; $display("FAIL call_latch: got %h/%h/%b expected D00A/0006/1", instr_out, PC_out, PC_hazard_out);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0, 16'($urandom));
            total++;
            if (dut_v !== exp_v() || valid_out !== 1'b0 || PC_hazard_out !== 1'b1) begin
                bad++; $display("FAIL call_bubble[%0d]: got %h expected %h", i, dut_v, exp_v());
            end
        end
        step(1'b0, 1'b1, 16'h000A, 16'h0);
        total++;
        if (imem_addr !== 16'h000A || PC_hazard_out !== 1'b0 || valid_out !== 1'b0) begin
            bad++; $display("FAIL call_redirect: got %h/%b/%b expected 000A/0/0", imem_addr, PC_hazard_out, valid_out);
        end
        step(1'b0, 1'b0, 16'h0, 16'h2000);
        total++;
        if (dut_v !== exp_v() || PC_out !== 16'h000B) begin
            bad++; $display("FAIL call_resume: got %h expected %h", dut_v, exp_v());
        end
    endtask

    task automatic test_stall_redirect();
        step(1'b1, 1'b0, 16'h0, 16'h3333);
        total++;
        if (dut_v !== exp_v()) begin
            bad++; $display("FAIL stall_hold: got %h expected %h", dut_v, exp_v());
        end
        step(1'b1, 1'b1, 16'h0040, 16'h3333);
        total++;
        if (imem_addr !== 16'h0040 || valid_out !== 1'b0 || instr_out !== 16'h0 || dut_v !== exp_v()) begin
            bad++; $display("FAIL stall_redirect: got %h expected %h", dut_v, exp_v());
        end
    endtask

    task automatic test_halt();
        step(1'b0, 1'b1, 16'h0010, 16'h0);
        step(1'b0, 1'b0, 16'h0, 16'hF000);
        total++;
        if (halted !== 1'b1 || imem_addr !== 16'h0010 || instr_out !== 16'hF000 || valid_out !== 1'b1) begin
            bad++; $display("FAIL halt_enter: got %h expected %h", dut_v, exp_v());
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 16'h0, 16'hF000);
            total++;
            if (halted !== 1'b1 || imem_addr !== 16'h0010 || valid_out !== 1'b0 || dut_v !== exp_v()) begin
                bad++; $display("FAIL halt_stay[%0d]: got %h expected %h", i, dut_v, exp_v());
            end
        end
        step(1'b0, 1'b1, 16'h0020, 16'h0);
        step(1'b0, 1'b0, 16'h0, 16'h4444);
        total++;
        if (halted !== 1'b0 || PC_out !== 16'h0021 || instr_out !== 16'h4444 || dut_v !== exp_v()) begin
            bad++; $display("FAIL halt_resume: got %h expected %h", dut_v, exp_v());
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 1'b1, 16'hFFFF, 16'h0);
        step(1'b0, 1'b0, 16'h0, 16'h1234);
        total++;
        if (PC_out !== 16'h0000 || imem_addr !== 16'h0000 || dut_v !== exp_v()) begin
            bad++; $display("FAIL wrap: got %h expected %h", dut_v, exp_v());
        end
    endtask

    task automatic test_timeout();
        logic exp_hz, exp_to;
`ifdef FETCH_HOLD_TIMEOUT_EN
        exp_hz = 1'b0; exp_to = 1'b1;
`else
        exp_hz = 1'b1; exp_to = 1'b0;
`endif
        step(1'b0, 1'b1, 16'h0030, 16'h0);
        step(1'b0, 1'b0, 16'h0, 16'hE000);
        step(1'b1, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 16'h0, 16'h5555);
        total++;
        if (PC_hazard_out !== exp_hz || hold_timeout !== exp_to || imem_addr !== 16'h0031 || dut_v !== exp_v()) begin
            bad++; $display("FAIL timeout_expire: got %h expected %h", dut_v, exp_v());
        end
        step(1'b0, 1'b0, 16'h0, 16'h6666);
        total++;
        if (dut_v !== exp_v()) begin
            bad++; $display("FAIL timeout_after: got %h expected %h", dut_v, exp_v());
        end
        step(1'b0, 1'b1, 16'h0050, 16'h0);
        total++;
        if (hold_timeout !== exp_to || dut_v !== exp_v()) begin
            bad++; $display("FAIL timeout_sticky: got %h expected %h", dut_v, exp_v());
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, 16'h0060, 16'h0);
            step(1'b0, 1'b0, 16'h0, (k == 0) ? 16'hD000 : 16'hF000);
            step(1'b0, 1'b0, 16'h0, 16'h0);
            rst = 1'b1;
            model_reset();
            #2;
            total++;
            if (dut_v !== 52'h0) begin
                bad++; $display("FAIL async_reset[%0d]: got %h expected %h", k, dut_v, 52'h0);
            end
            rst = 1'b0;
            step(1'b0, 1'b0, 16'h0, 16'h7777);
            total++;
            if (PC_out !== 16'h0001 || instr_out !== 16'h7777 || dut_v !== exp_v()) begin
                bad++; $display("FAIL post_reset_fetch[%0d]: got %h expected %h", k, dut_v, exp_v());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        int          r;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 31));
            if (r < 2)      op = 4'hD;
            else if (r < 4) op = 4'hE;
            else if (r == 4) op = 4'hF;
            else if (r < 8) op = 4'hC;
            else            op = 4'($urandom_range(0, 11));
            step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 16'($urandom),
                 {op, 12'($urandom)});
            total++;
            if (dut_v !== exp_v()) begin
                bad++; $display("FAIL random[%0d]: got %h expected %h", i, dut_v, exp_v());
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0; imem_instr = 16'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_call();
        test_stall_redirect();
        test_halt();
        test_wrap();
        test_timeout();
        test_async_reset();
        apply_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
